// File: rtl/line_fill_mem_if.sv
// Line-transfer channel between the cache refill/evict path and the backing store.
// master = cache side, slave = memory responder.
interface line_fill_mem_if #(
    parameter int BLK_W  = 13,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [BLK_W-1:0]  req_blk;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_done;

    modport master (
        output req_valid, req_write, req_blk, rd_ready, wr_valid, wr_data,
        input  req_ready, rd_valid, rd_data, rd_last, wr_ready, wr_done
    );

    modport slave (
        input  req_valid, req_write, req_blk, rd_ready, wr_valid, wr_data,
        output req_ready, rd_valid, rd_data, rd_last, wr_ready, wr_done
    );
endinterface

// File: rtl/line_fill_mem.sv
// Backing-store responder: whole-line refills and write-backs with a fixed access latency.
// state      | meaning
// S_IDLE     | ready for a line request
// S_WAIT     | modelling access latency (LATENCY cycles)
// S_RD_BURST | streaming refill beats to the cache
// S_WR_BURST | absorbing write-back beats from the cache
// S_WR_DONE  | one-cycle write-back commit pulse
module line_fill_mem #(
    parameter int BLK_W   = 13,
    parameter int WORDS   = 16,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    line_fill_mem_if.slave  bus
);
    localparam int BEAT_W = $clog2(WORDS);
    localparam int ADDR_W = BLK_W + BEAT_W;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RD_BURST,
        S_WR_BURST,
        S_WR_DONE
    } state_t;

    state_t state, state_nxt;

    logic [3:0]        lat_cnt;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] beat_inc;
    logic [BLK_W-1:0]  blk_q;
    logic              write_q;
    logic              rd_valid_q;
    logic              rd_last_q;
    logic [DATA_W-1:0] rd_data_q;

    logic accept;
    logic rd_fire;
    logic wr_fire;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    assign beat_inc = beat + BEAT_W'(1);
    assign accept   = (state == S_IDLE) && bus.req_valid;
    assign rd_fire  = (state == S_RD_BURST) && rd_valid_q && bus.rd_ready;
    assign wr_fire  = (state == S_WR_BURST) && bus.wr_valid;

    assign bus.req_ready = (state == S_IDLE) && rst_n;
    assign bus.wr_ready  = (state == S_WR_BURST);
    assign bus.wr_done   = (state == S_WR_DONE);
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.rd_data   = rd_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (bus.req_valid) state_nxt = S_WAIT;
            S_WAIT:     if (lat_cnt == 4'd0) state_nxt = write_q ? S_WR_BURST : S_RD_BURST;
            S_RD_BURST: if (rd_fire && beat == BEAT_LAST) state_nxt = S_IDLE;
            S_WR_BURST: if (wr_fire && beat == BEAT_LAST) state_nxt = S_WR_DONE;
            S_WR_DONE:  state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_cnt    <= 4'd0;
            beat       <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            if (accept) begin
                blk_q   <= bus.req_blk;
                write_q <= bus.req_write;
                lat_cnt <= 4'(LATENCY - 1);
                beat    <= '0;
            end
            if (state == S_WAIT) begin
                if (lat_cnt != 4'd0) begin
                    lat_cnt <= lat_cnt - 4'd1;
                end else if (!write_q) begin
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= mem[{blk_q, BEAT_W'(0)}];
                    rd_last_q  <= 1'b0;
                end
            end
            // next refill word is fetched only on acceptance, so data holds across stalls
            if (rd_fire) begin
                if (beat == BEAT_LAST) begin
                    rd_valid_q <= 1'b0;
                    rd_last_q  <= 1'b0;
                    beat       <= '0;
                end else begin
                    beat      <= beat_inc;
                    rd_data_q <= mem[{blk_q, beat_inc}];
                    rd_last_q <= (beat_inc == BEAT_LAST);
                end
            end
            if (wr_fire) beat <= beat_inc;
        end
    end

    // storage survives reset; a write is suppressed on the edge that resets the block
    always_ff @(posedge clk) begin
        if (rst_n && wr_fire) mem[{blk_q, beat}] <= bus.wr_data;
    end
endmodule

// File: tb/tb_line_fill_mem.sv
// Directed bench for line_fill_mem: refills, write-backs, stalls, gaps, boundaries, mid-burst reset.
module tb_line_fill_mem;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] model [logic [16:0]];

    line_fill_mem_if #(.BLK_W(13), .DATA_W(32)) bus ();

    line_fill_mem #(.BLK_W(13), .WORDS(16), .DATA_W(32), .LATENCY(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [12:0] blk, input int k);
        logic [16:0] key;
        key = {blk, 4'(k)};
        if (model.exists(key)) return model[key];
        return 32'h0;
    endfunction

    task automatic issue(input logic [12:0] blk, input logic wr);
        int n;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_blk   = blk;
        bus.req_write = wr;
        tick();
        bus.req_valid = 1'b0;
        bus.req_blk   = 13'h0AAA;
        bus.req_write = ~wr;
    endtask

    task automatic read_line(input logic [12:0] blk, input bit stall);
        int n;
        int k;
        int c;
        bit rdy;
        issue(blk, 1'b0);
        bus.rd_ready = 1'b1;
        n = 0;
        while (!bus.rd_valid && n < 20) begin
            tick();
            n++;
        end
        chk("rd_latency", 32'(n), 32'd4);
        k = 0;
        c = 0;
        while (k < 16 && c < 200) begin
            rdy = !stall || (c % 3 == 0);
            bus.rd_ready = rdy;
            chk("rd_valid", 32'(bus.rd_valid), 32'd1);
            chk("rd_data", bus.rd_data, exp_word(blk, k));
            chk("rd_last", 32'(bus.rd_last), 32'(k == 15));
            tick();
            c++;
            if (rdy) k++;
        end
        bus.rd_ready = 1'b0;
        chk("rd_beats", 32'(k), 32'd16);
        chk("rd_valid_end", 32'(bus.rd_valid), 32'd0);
        chk("rd_last_end", 32'(bus.rd_last), 32'd0);
        chk("req_ready_after_rd", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic write_line(input logic [12:0] blk, input logic [31:0] base, input bit const_data,
                              input bit gaps, input int abort_at, output int cycles);
        int n;
        int k;
        int g3;
        int g9;
        bit v;
        bit hs;
        logic [31:0] w;
        issue(blk, 1'b1);
        n  = 0;
        k  = 0;
        g3 = 0;
        g9 = 0;
        while (k < 16 && n < 100) begin
            w = const_data ? base : base + 32'(k);
            v = 1'b1;
            if (gaps && bus.wr_ready && ((k == 3 && g3 < 2) || (k == 9 && g9 < 2))) begin
                v = 1'b0;
                if (k == 3) g3++;
                else        g9++;
            end
            if (bus.wr_ready && k == abort_at) begin
                rst_n        = 1'b0;
                bus.wr_valid = 1'b1;
                bus.wr_data  = w;
                tick();
                bus.wr_valid = 1'b0;
                cycles = n;
                return;
            end
            bus.wr_valid = v;
            bus.wr_data  = w;
            hs = v && bus.wr_ready;
            tick();
            n++;
            if (hs) begin
                model[{blk, 4'(k)}] = w;
                k++;
            end
        end
        bus.wr_valid = 1'b0;
        chk("wr_beats", 32'(k), 32'd16);
        chk("wr_ready_end", 32'(bus.wr_ready), 32'd0);
        chk("wr_done_pulse", 32'(bus.wr_done), 32'd1);
        tick();
        chk("wr_done_once", 32'(bus.wr_done), 32'd0);
        chk("req_ready_after_wr", 32'(bus.req_ready), 32'd1);
        cycles = n;
    endtask

    initial begin
        int cyc;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_blk   = '0;
        bus.rd_ready  = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;

        // reset state
        tick();
        tick();
        tick();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_last", 32'(bus.rd_last), 32'd0);
        chk("rst_rd_data", bus.rd_data, 32'h0);
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("rst_wr_done", 32'(bus.wr_done), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("req_ready_after_rst", 32'(bus.req_ready), 32'd1);

        // refill of untouched block 0 returns zeros
        read_line(13'h0000, 1'b0);

        // gap-free write-back, then read it back with and without stalls
        write_line(13'h1ABC, 32'hA000_0000, 1'b0, 1'b0, -1, cyc);
        chk("wr_cycles_nogap", 32'(cyc), 32'd20);
        chk("model_1abc_0", exp_word(13'h1ABC, 0), 32'hA000_0000);
        chk("model_1abc_15", exp_word(13'h1ABC, 15), 32'hA000_000F);
        read_line(13'h1ABC, 1'b0);
        read_line(13'h1ABC, 1'b1);

        // write-back with two 2-cycle gaps costs 4 extra cycles
        write_line(13'h0005, 32'h5000_0000, 1'b0, 1'b1, -1, cyc);
        chk("wr_cycles_gaps", 32'(cyc), 32'd24);
        read_line(13'h0005, 1'b0);

        // top block, then isolation of block 0
        write_line(13'h1FFF, 32'hFFFF_FFFF, 1'b1, 1'b0, -1, cyc);
        chk("wr_cycles_1fff", 32'(cyc), 32'd20);
        read_line(13'h0000, 1'b0);
        read_line(13'h1FFF, 1'b0);
        chk("model_1fff_7", exp_word(13'h1FFF, 7), 32'hFFFF_FFFF);

        // old contents of block 0x0010, then a write-back cut by reset at beat 7
        write_line(13'h0010, 32'hB000_0000, 1'b0, 1'b0, -1, cyc);
        write_line(13'h0010, 32'hC000_0000, 1'b0, 1'b0, 7, cyc);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd0);
        chk("abort_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("abort_wr_done", 32'(bus.wr_done), 32'd0);
        chk("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("abort_rd_data", bus.rd_data, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("abort_req_ready_rise", 32'(bus.req_ready), 32'd1);
        chk("model_0010_6", exp_word(13'h0010, 6), 32'hC000_0006);
        chk("model_0010_7", exp_word(13'h0010, 7), 32'hB000_0007);
        read_line(13'h0010, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
